// File: rtl/tdsp_write_demux_if.sv
// Write-side bus of the TDSP write demultiplexer: the TDSP write port, the scratch
// memory write port and the data sample memory request/acknowledge port.
interface tdsp_write_demux_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          t_write;
    logic          t_ds_sel;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic          t_stall;

    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic          ds_req;
    logic [AW-1:0] ds_addr;
    logic [DW-1:0] ds_wdata;
    logic          ds_ack;
    logic          ds_err;

    logic          wr_idle;

    // master: TDSP plus both memories (the environment); slave: the demux itself
    modport master (
        output t_write, t_ds_sel, t_addr, t_wdata, ds_ack,
        input  t_stall, mem_write, mem_addr, mem_wdata,
        input  ds_req, ds_addr, ds_wdata, ds_err, wr_idle
    );

    modport slave (
        input  t_write, t_ds_sel, t_addr, t_wdata, ds_ack,
        output t_stall, mem_write, mem_addr, mem_wdata,
        output ds_req, ds_addr, ds_wdata, ds_err, wr_idle
    );
endinterface

// File: rtl/tdsp_write_demux.sv
// Buffers TDSP writes in a 2-entry FIFO and drains them in order to either the scratch
// memory (single-cycle write) or the data sample memory (req/ack with timeout).
module tdsp_write_demux #(
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int TO_CYC = 16
) (
    input logic               clk,
    input logic               reset,
    tdsp_write_demux_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCR_WR = 2'd1,
        DS_REQ = 2'd2
    } state_t;

    typedef struct packed {
        logic          sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    localparam int            CW      = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

    state_t        state, state_nx;
    entry_t        fifo [2];
    entry_t        head;
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic          full, push, pop, timeout;
    logic [CW-1:0] to_cnt;
    logic          ds_err_q;
    logic [AW-1:0] mem_addr_q, ds_addr_q;
    logic [DW-1:0] mem_wdata_q, ds_wdata_q;

    // Stall comes from the registered count only, so a same-cycle pop never frees a slot.
    assign full    = (count == 2'd2);
    assign push    = bus.t_write && !full;
    assign pop     = (state == IDLE) && (count != 2'd0);
    assign head    = fifo[rd_ptr];
    assign timeout = (state == DS_REQ) && (to_cnt == TO_LAST) && !bus.ds_ack;

    // NOTE: storage is only ever read after being written, so it needs no reset and
    // stays a plain register array without a reset net fanning out to every bit.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {bus.t_ds_sel, bus.t_addr, bus.t_wdata};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop) state_nx = head.sel ? DS_REQ : SCR_WR;
            SCR_WR:  state_nx = IDLE;
            DS_REQ:  if (bus.ds_ack || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The timeout counter sits at zero outside DS_REQ, which clears it on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt      <= '0;
            ds_err_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ds_addr_q   <= '0;
            ds_wdata_q  <= '0;
        end else begin
            to_cnt   <= (state == DS_REQ) ? to_cnt + CW'(1) : '0;
            ds_err_q <= timeout;
            if (pop && !head.sel) begin
                mem_addr_q  <= head.addr;
                mem_wdata_q <= head.data;
            end
            if (pop && head.sel) begin
                ds_addr_q  <= head.addr;
                ds_wdata_q <= head.data;
            end
        end
    end

    assign bus.t_stall   = full;
    assign bus.mem_write = (state == SCR_WR);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ds_req    = (state == DS_REQ);
    assign bus.ds_addr   = ds_addr_q;
    assign bus.ds_wdata  = ds_wdata_q;
    assign bus.ds_err    = ds_err_q;
    assign bus.wr_idle   = (state == IDLE) && (count == 2'd0);

endmodule
